// File: rtl/mux_2.sv
// 2:1 mux with registered select/data copies and a saturating select-toggle counter.
// Define MUX_2_REG_OUT_EN to drive y from the registered data bit instead of the combinational select.
module mux_2 #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       d0,
  input  logic             s,
  input  logic             clr,
  output logic             y,
  output logic             y_q,
  output logic             s_q,
  output logic [CNT_W-1:0] tog_cnt,
  output logic             tog_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             sel;
  logic             toggle;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_nxt;

  assign sel    = s ? d0[1] : d0[0];
  assign toggle = (s != s_q);

  // Counter saturates at all-ones; clear beats a simultaneous toggle.
  always_comb begin
    cnt_nxt = tog_cnt;
    sat_nxt = tog_sat;
    if (clr) begin
      cnt_nxt = '0;
      sat_nxt = 1'b0;
    end else if (toggle && (tog_cnt != CNT_MAX)) begin
      cnt_nxt = tog_cnt + CNT_W'(1);
      if (cnt_nxt == CNT_MAX) begin
        sat_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q     <= 1'b0;
      s_q     <= 1'b0;
      tog_cnt <= '0;
      tog_sat <= 1'b0;
    end else begin
      y_q     <= sel;
      s_q     <= s;
      tog_cnt <= cnt_nxt;
      tog_sat <= sat_nxt;
    end
  end

`ifdef MUX_2_REG_OUT_EN
  assign y = y_q;
`else
  assign y = sel;
`endif

endmodule

// File: tb/tb_mux_2.sv
// Scoreboard bench for mux_2: stimulus queues expected values, a monitor process pops and compares them.
module tb_mux_2;

  localparam int unsigned CNT_W    = 8;
  localparam int          CNT_MAXI = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       d0;
  logic             s;
  logic             clr;
  logic             y;
  logic             y_q;
  logic             s_q;
  logic [CNT_W-1:0] tog_cnt;
  logic             tog_sat;

  mux_2 #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .d0(d0), .s(s), .clr(clr),
    .y(y), .y_q(y_q), .s_q(s_q), .tog_cnt(tog_cnt), .tog_sat(tog_sat)
  );

  always #10 clk = ~clk;

  typedef enum int {F_Y, F_YQ, F_SQ, F_CNT, F_SAT} fld_e;
  typedef struct {
    string name;
    fld_e  f;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  event drained_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference state
  logic m_yq, m_sq, m_sat;
  int   m_cnt;

  // monitor: drains the expectation queue whenever a sample point is announced
  initial begin
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        exp_t e;
        int   act;
        e = exp_q.pop_front();
        case (e.f)
          F_Y:     act = int'(y);
          F_YQ:    act = int'(y_q);
          F_SQ:    act = int'(s_q);
          F_CNT:   act = int'(tog_cnt);
          default: act = int'(tog_sat);
        endcase
        n_cmp++;
        if (act != e.val) begin
          n_bad++;
          $display("FAIL %s: got %0d expected %0d (t=%0t)", e.name, act, e.val, $time);
        end
      end
      ->drained_ev;
    end
  end

  task automatic push(input string nm, input fld_e f, input int v);
    exp_t e;
    e.name = nm;
    e.f    = f;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic sync();
    fork
      begin
        ->sample_ev;
        @(drained_ev);
      end
      begin
        #50;
        n_cmp++;
        n_bad++;
        $display("FAIL monitor_timeout: got %0d pending expected 0", exp_q.size());
      end
    join_any
    disable fork;
  endtask

  function automatic logic sel_of(input logic s_i, input logic [1:0] d_i);
    return s_i ? d_i[1] : d_i[0];
  endfunction

  task automatic expect_state(input string tag);
`ifdef MUX_2_REG_OUT_EN
    push({tag, ".y"}, F_Y, int'(m_yq));
`else
    push({tag, ".y"}, F_Y, int'(sel_of(s, d0)));
`endif
    push({tag, ".y_q"},     F_YQ,  int'(m_yq));
    push({tag, ".s_q"},     F_SQ,  int'(m_sq));
    push({tag, ".tog_cnt"}, F_CNT, m_cnt);
    push({tag, ".tog_sat"}, F_SAT, int'(m_sat));
    sync();
  endtask

  task automatic model_edge(input logic s_i, input logic [1:0] d_i, input logic clr_i);
    m_yq = sel_of(s_i, d_i);
    if (clr_i) begin
      m_cnt = 0;
      m_sat = 1'b0;
    end else if ((s_i != m_sq) && (m_cnt != CNT_MAXI)) begin
      m_cnt++;
      if (m_cnt == CNT_MAXI) m_sat = 1'b1;
    end
    m_sq = s_i;
  endtask

  task automatic model_reset();
    m_yq  = 1'b0;
    m_sq  = 1'b0;
    m_cnt = 0;
    m_sat = 1'b0;
  endtask

  // drive on the falling edge, check 1 unit after the rising edge
  task automatic step(input logic s_i, input logic [1:0] d_i, input logic clr_i, input string tag);
    @(negedge clk);
    s   = s_i;
    d0  = d_i;
    clr = clr_i;
    @(posedge clk);
    model_edge(s_i, d_i, clr_i);
    #1;
    expect_state(tag);
  endtask

  logic [7:0] walk_exp;
  logic [2:0] walk_v;

  initial begin
    reset = 1'b1;
    s     = 1'b0;
    d0    = 2'b00;
    clr   = 1'b0;
    model_reset();
    walk_exp = 8'b1100_1010;

    // truth-table walk while reset holds the registers
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      walk_v = 3'(i);
      s      = walk_v[2];
      d0     = walk_v[1:0];
      #1;
`ifdef MUX_2_REG_OUT_EN
      push($sformatf("walk%0d.y", i), F_Y, 0);
`else
      push($sformatf("walk%0d.y", i), F_Y, int'(walk_exp[i]));
`endif
      sync();
    end
    expect_state("reset");

    @(negedge clk);
    reset = 1'b0;
    s     = 1'b0;
    d0    = 2'b10;
    step(1'b0, 2'b10, 1'b0, "pre_sel");

    // s rises mid-cycle with d0=10
    @(negedge clk);
    s = 1'b1;
    #1;
`ifdef MUX_2_REG_OUT_EN
    push("sel_mid.y", F_Y, 0);
`else
    push("sel_mid.y", F_Y, 1);
`endif
    push("sel_mid.y_q", F_YQ, 0);
    sync();
    @(posedge clk);
    model_edge(1'b1, 2'b10, 1'b0);
    #1;
    expect_state("sel_edge");
    push("sel_edge.y_const", F_Y, 1);
    push("sel_edge.cnt_const", F_CNT, 1);
    sync();
    n_cmp++;
    if (y !== 1'b1) begin
      n_bad++;
      $display("FAIL sel_edge.y_direct: got %0d expected 1", y);
    end
    n_cmp++;
    if (tog_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL sel_edge.cnt_direct: got %0d expected 1", tog_cnt);
    end

    // toggle every cycle: 300 toggles in total
    for (int i = 0; i < 299; i++) begin
      step(~m_sq, 2'(i), 1'b0, $sformatf("tog%0d", i));
    end
    push("sat.cnt", F_CNT, 255);
    push("sat.flag", F_SAT, 1);
    sync();
    n_cmp++;
    if (tog_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL sat.cnt_direct: got %0d expected 255", tog_cnt);
    end
    n_cmp++;
    if (tog_sat !== 1'b1) begin
      n_bad++;
      $display("FAIL sat.flag_direct: got %0d expected 1", tog_sat);
    end

    step(m_sq, 2'b01, 1'b1, "clr_hold");
    push("clr_hold.cnt0", F_CNT, 0);
    push("clr_hold.sat0", F_SAT, 0);
    sync();
    n_cmp++;
    if (tog_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL clr_hold.cnt_direct: got %0d expected 0", tog_cnt);
    end
    n_cmp++;
    if (tog_sat !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_hold.sat_direct: got %0d expected 0", tog_sat);
    end

    for (int i = 0; i < 5; i++) begin
      step(~m_sq, 2'(i), 1'b0, $sformatf("five%0d", i));
    end
    push("five.cnt", F_CNT, 5);
    sync();
    n_cmp++;
    if (tog_cnt !== 8'd5) begin
      n_bad++;
      $display("FAIL five.cnt_direct: got %0d expected 5", tog_cnt);
    end

    step(~m_sq, 2'b11, 1'b1, "clr_tog");
    push("clr_tog.cnt0", F_CNT, 0);
    push("clr_tog.sat0", F_SAT, 0);
    sync();
    n_cmp++;
    if (tog_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL clr_tog.cnt_direct: got %0d expected 0", tog_cnt);
    end
    n_cmp++;
    if (tog_sat !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_tog.sat_direct: got %0d expected 0", tog_sat);
    end
    step(~m_sq, 2'b00, 1'b0, "after_clr");
    push("after_clr.cnt1", F_CNT, 1);
    sync();
    n_cmp++;
    if (tog_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL after_clr.cnt_direct: got %0d expected 1", tog_cnt);
    end

    for (int i = 0; i < 9; i++) begin
      step(~m_sq, 2'b11, 1'b0, $sformatf("ten%0d", i));
    end
    push("ten.cnt", F_CNT, 10);
    push("ten.y_q", F_YQ, 1);
    sync();
    n_cmp++;
    if (tog_cnt !== 8'd10) begin
      n_bad++;
      $display("FAIL ten.cnt_direct: got %0d expected 10", tog_cnt);
    end
    n_cmp++;
    if (y_q !== 1'b1) begin
      n_bad++;
      $display("FAIL ten.y_q_direct: got %0d expected 1", y_q);
    end

    // async reset between edges
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    push("arst.cnt", F_CNT, 0);
    push("arst.y_q", F_YQ, 0);
    push("arst.s_q", F_SQ, 0);
    push("arst.sat", F_SAT, 0);
    sync();
    n_cmp++;
    if (tog_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL arst.cnt_direct: got %0d expected 0", tog_cnt);
    end
    n_cmp++;
    if (y_q !== 1'b0) begin
      n_bad++;
      $display("FAIL arst.y_q_direct: got %0d expected 0", y_q);
    end
    n_cmp++;
    if (s_q !== 1'b0) begin
      n_bad++;
      $display("FAIL arst.s_q_direct: got %0d expected 0", s_q);
    end
    n_cmp++;
    if (tog_sat !== 1'b0) begin
      n_bad++;
      $display("FAIL arst.sat_direct: got %0d expected 0", tog_sat);
    end

    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 2'b01, 1'b0, "post_rst");
    push("post_rst.cnt1", F_CNT, 1);
    push("post_rst.y_q0", F_YQ, 0);
    sync();
    n_cmp++;
    if (tog_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL post_rst.cnt_direct: got %0d expected 1", tog_cnt);
    end
    n_cmp++;
    if (y_q !== 1'b0) begin
      n_bad++;
      $display("FAIL post_rst.y_q_direct: got %0d expected 0", y_q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_2.md
MUX_2 -- requirements
Module: mux_2

Interface
REQ-001 Parameter: CNT_W, default 8, width of the select-toggle counter; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: d0  input  2  data inputs; d0[0] is the s=0 leg, d0[1] is the s=1 leg.
REQ-005 Port: s  input  1  select.
REQ-006 Port: clr  input  1  synchronous clear of toggle counter and sticky flag.
REQ-007 Port: y  output  1  mux output.
REQ-008 Port: y_q  output  1  registered copy of the selected data bit.
REQ-009 Port: s_q  output  1  registered select, used for toggle detection.
REQ-010 Port: tog_cnt  output  CNT_W  count of s transitions sampled on clk.
REQ-011 Port: tog_sat  output  1  sticky flag; set when tog_cnt reaches all-ones.

Function
REQ-012 The mux SHALL compute sel = s ? d0[1] : d0[0]; full truth table: s=0 -> d0[0], s=1 -> d0[1], for all four d0 values.
REQ-013 With the macro of REQ-023 undefined, y SHALL equal sel combinationally, zero clock latency, no dependence on clk or reset.
REQ-014 y_q SHALL load sel on every rising clk edge (1-cycle latency) regardless of clr.
REQ-015 s_q SHALL load s on every rising clk edge.
REQ-016 A toggle SHALL be detected on an edge where s differs from s_q.
REQ-017 On a toggle edge with clr=0, tog_cnt SHALL increment by 1 unless already all-ones, where it SHALL hold (saturate, no wrap).
REQ-018 tog_sat SHALL set on the edge where tog_cnt becomes all-ones and SHALL stay set until clr or reset.
REQ-019 clr=1 SHALL zero tog_cnt and tog_sat on that edge; clr wins over a simultaneous toggle (the toggle is not counted).
REQ-020 X/Z on s SHALL NOT be required to resolve; implementation uses a plain 2:1 select.

Reset
REQ-021 reset=1 SHALL asynchronously force y_q=0, s_q=0, tog_cnt=0, tog_sat=0, independent of clk.
REQ-022 Reset asserted mid-operation SHALL discard all count state; first edge after deassertion samples normally (s=1 on that edge counts as a toggle since s_q=0).

Configuration
REQ-023 Macro MUX_2_REG_OUT_EN: when defined, y SHALL be driven from y_q (1-cycle latency, reset value 0); when undefined, y SHALL be combinational per REQ-013. All other ports behave identically in both builds.

Verification
REQ-024 Combinational build, walk (s,d0[1],d0[0]) 000..111 at 1-time-unit steps -> y = 0,1,0,1,0,0,1,1.
REQ-025 Registered build, d0=2'b10, s 0->1 before an edge -> y stays 0 until that edge, then 1 after it; y_q identical.
REQ-026 Toggle s every cycle for 300 cycles, CNT_W=8 -> tog_cnt climbs to 255 and holds; tog_sat=1 from the count-255 edge.
REQ-027 tog_cnt=5, assert clr on a cycle where s toggles -> tog_cnt=0, tog_sat=0 next edge; next toggle yields 1.
REQ-028 Assert reset asynchronously between edges with tog_cnt=10, y_q=1 -> tog_cnt=0, y_q=0, s_q=0 immediately, before the next edge.
